inv_sub_shift_unit: RTL and testbench

//  Iterative InvSubBytes + InvShiftRows engine for the AES decrypt datapath; reverse of forward SubBytes.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/inv_sub_shift_unit_if.sv | 22 ++
 rtl/Inv_S_Box.sv | 30 +++
 rtl/inv_sub_shift_unit.sv | 87 ++++++++
 tb/tb_inv_sub_shift_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES decrypt-datapath types and the InvShiftRows source-index helper.
package aes_pkg;

    localparam int unsigned AES_NBYTES = 16;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    // Output byte j (row r, col c) comes from row r, column (c - r) mod 4 of the input.
    function automatic logic [3:0] inv_shift_idx(input logic [3:0] j);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] src_col;
        r       = j[1:0];
        c       = j[3:2];
        src_col = c - r;
        return {src_col, r};
    endfunction

endpackage

// File: rtl/inv_sub_shift_unit_if.sv
// Valid/ready input and output streams of the InvSubBytes/InvShiftRows engine.
interface inv_sub_shift_unit_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_data;
    logic   out_valid;
    logic   out_ready;
    state_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/Inv_S_Box.sv
// Combinational AES inverse S-box lookup.
module Inv_S_Box
    import aes_pkg::*;
(
    input  byte_t din,
    output byte_t dout
);

    localparam byte_t TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign dout = TBL[din];

endmodule

// File: rtl/inv_sub_shift_unit.sv
// Iterative InvSubBytes + InvShiftRows: NUM_LANES bytes per cycle, valid/ready on both sides.
module inv_sub_shift_unit
    import aes_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_sub_shift_unit_if.slave  bus,
    output logic                 busy
);

    localparam int unsigned STEPS = AES_NBYTES / NUM_LANES;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4 &&
        NUM_LANES != 8 && NUM_LANES != 16) begin : g_bad_lanes
        $error("inv_sub_shift_unit: NUM_LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_t          state;
    fsm_t          state_nxt;
    logic [CW-1:0] step;
    state_t        cap_q;
    state_t        res_q;
    logic [3:0]    dst      [NUM_LANES];
    byte_t         lane_in  [NUM_LANES];
    byte_t         lane_out [NUM_LANES];

    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = res_q;
    assign busy          = (state == RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid && bus.in_ready) state_nxt = RUN;
            RUN:     if (step == LAST)                  state_nxt = DONE;
            DONE:    if (bus.out_ready)                 state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Each lane owns destination byte step*NUM_LANES+l and fetches its shifted source byte.
    always_comb begin
        dst     = '{default: '0};
        lane_in = '{default: '0};
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            dst[l]     = 4'(32'(step) * NUM_LANES + l);
            lane_in[l] = cap_q[8 * (15 - 32'(inv_shift_idx(dst[l]))) +: 8];
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        Inv_S_Box u_sbox (
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step  <= '0;
            cap_q <= '0;
            res_q <= '0;
        end else if (state == IDLE && bus.in_valid && bus.in_ready) begin
            cap_q <= bus.in_data;
            step  <= '0;
        end else if (state == RUN) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                res_q[8 * (15 - 32'(dst[l])) +: 8] <= lane_out[l];
            end
            if (step != LAST) step <= step + 1'b1;
        end
    end

endmodule

// File: tb/tb_inv_sub_shift_unit.sv
// Directed bench for inv_sub_shift_unit with NUM_LANES = 4, 1 and 16 instances.
module tb_inv_sub_shift_unit;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy4, busy1, busy16;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    localparam state_t V_T2  = {8'h7c, 8'h7c, {14{8'h63}}};
    localparam state_t E_T2  = 128'h01000000_00010000_00000000_00000000;
    localparam state_t V_SEQ = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam state_t E_SEQ = 128'h52f3a338_3009d79e_bf366afb_8140a5d5;

    inv_sub_shift_unit_if b4 ();
    inv_sub_shift_unit_if b1 ();
    inv_sub_shift_unit_if b16 ();

    inv_sub_shift_unit #(.NUM_LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4), .busy(busy4)
    );
    inv_sub_shift_unit #(.NUM_LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy1)
    );
    inv_sub_shift_unit #(.NUM_LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16), .busy(busy16)
    );

    // Drives one state through the 4-lane unit; lat counts negedges from accept to out_valid.
    task automatic xfer4(input state_t d, output state_t q, output int lat);
        @(negedge clk);
        b4.in_data   = d;
        b4.in_valid  = 1'b1;
        b4.out_ready = 1'b0;
        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.in_data  = ~d;
        lat = 0;
        while (b4.out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        q = b4.out_data;
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (b4.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", b4.in_ready); end
        n_cmp++; if (b4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", b4.out_valid); end
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy4); end
        n_cmp++; if (b4.out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", b4.out_data); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b want 1", b4.in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        @(negedge clk);
        b4.in_data   = {16{8'h63}};
        b4.in_valid  = 1'b1;
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.in_data  = '1;
        n_cmp++; if (b4.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_run: got %b want 0", b4.in_ready); end
        n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL basic_busy_run: got %b want 1", busy4); end
        lat = 0;
        while (b4.out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_cmp++; if (b4.out_data !== '0) begin n_err++; $display("FAIL basic_out_data: got %h want 0", b4.out_data); end
        n_cmp++; if ({b4.in_ready, busy4} !== 2'b00) begin n_err++; $display("FAIL basic_done_flags: got in_ready=%b busy=%b want 0 0", b4.in_ready, busy4); end
        @(negedge clk);
        b4.out_ready = 1'b0;
        n_cmp++; if ({b4.out_valid, b4.in_ready} !== 2'b01) begin n_err++; $display("FAIL basic_after_handshake: got out_valid=%b in_ready=%b want 0 1", b4.out_valid, b4.in_ready); end
    endtask

    task automatic test_mapping();
        state_t q;
        int     lat;
        xfer4(V_T2, q, lat);
        n_cmp++; if (q !== E_T2) begin n_err++; $display("FAIL map_row_shift: got %h want %h", q, E_T2); end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL map_latency: got %0d want 4", lat); end
        xfer4(V_SEQ, q, lat);
        n_cmp++; if (q !== E_SEQ) begin n_err++; $display("FAIL map_seq: got %h want %h", q, E_SEQ); end
    endtask

    task automatic test_table();
        byte_t  tin  [4] = '{8'h16, 8'h00, 8'h52, 8'hed};
        byte_t  tout [4] = '{8'hff, 8'h52, 8'h48, 8'h53};
        state_t q;
        int     lat;
        for (int i = 0; i < 4; i++) begin
            xfer4({16{tin[i]}}, q, lat);
            n_cmp++; if (q !== {16{tout[i]}}) begin n_err++; $display("FAIL table_%h: got %h want %h", tin[i], q, {16{tout[i]}}); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        b4.in_data   = V_SEQ;
        b4.in_valid  = 1'b1;
        b4.out_ready = 1'b0;
        @(negedge clk);
        b4.in_valid = 1'b0;
        lat = 0;
        while (b4.out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (b4.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_reach_done: got out_valid=%b want 1 within 64 cycles", b4.out_valid); end
        for (int i = 0; i < 10; i++) begin
            b4.in_valid = (i % 2 == 0);
            b4.in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            n_cmp++;
            if ({b4.out_valid, b4.in_ready, b4.out_data} !== {1'b1, 1'b0, E_SEQ}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got valid=%b ready=%b data=%h want 1 0 %h",
                         i, b4.out_valid, b4.in_ready, b4.out_data, E_SEQ);
            end
        end
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.out_ready = 1'b0;
        n_cmp++; if ({b4.out_valid, b4.in_ready, busy4} !== 3'b010) begin n_err++; $display("FAIL bp_release: got valid=%b ready=%b busy=%b want 0 1 0", b4.out_valid, b4.in_ready, busy4); end
    endtask

    task automatic test_reset_mid_run();
        state_t q;
        int     lat;
        bit     seen = 1'b0;
        @(negedge clk);
        b4.in_data  = V_T2;
        b4.in_valid = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({b4.out_valid, busy4, b4.in_ready} !== 3'b000) begin n_err++; $display("FAIL midrst_flags: got valid=%b busy=%b ready=%b want 0 0 0", b4.out_valid, busy4, b4.in_ready); end
        n_cmp++; if (b4.out_data !== '0) begin n_err++; $display("FAIL midrst_out_data: got %h want 0", b4.out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b4.out_valid !== 1'b0 || busy4 !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_output: got activity=%b want 0", seen); end
        xfer4(V_SEQ, q, lat);
        n_cmp++; if (q !== E_SEQ) begin n_err++; $display("FAIL midrst_next_state: got %h want %h", q, E_SEQ); end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    endtask

    task automatic test_lanes();
        state_t vin [2] = '{V_T2, V_SEQ};
        state_t vexp [2] = '{E_T2, E_SEQ};
        int     cnt, lat1, lat16;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            b1.in_data  = vin[v];  b1.in_valid  = 1'b1; b1.out_ready  = 1'b0;
            b16.in_data = vin[v];  b16.in_valid = 1'b1; b16.out_ready = 1'b0;
            @(negedge clk);
            b1.in_valid  = 1'b0;
            b16.in_valid = 1'b0;
            cnt = 0; lat1 = -1; lat16 = -1;
            while ((lat1 < 0 || lat16 < 0) && cnt < 64) begin
                @(negedge clk);
                cnt++;
                if (lat1 < 0 && b1.out_valid === 1'b1) lat1 = cnt;
                if (lat16 < 0 && b16.out_valid === 1'b1) lat16 = cnt;
            end
            n_cmp++; if (lat1 !== 16) begin n_err++; $display("FAIL lanes1_latency_%0d: got %0d want 16", v, lat1); end
            n_cmp++; if (lat16 !== 1) begin n_err++; $display("FAIL lanes16_latency_%0d: got %0d want 1", v, lat16); end
            n_cmp++; if (b1.out_data !== vexp[v]) begin n_err++; $display("FAIL lanes1_data_%0d: got %h want %h", v, b1.out_data, vexp[v]); end
            n_cmp++; if (b16.out_data !== vexp[v]) begin n_err++; $display("FAIL lanes16_data_%0d: got %h want %h", v, b16.out_data, vexp[v]); end
            b1.out_ready  = 1'b1;
            b16.out_ready = 1'b1;
            @(negedge clk);
            b1.out_ready  = 1'b0;
            b16.out_ready = 1'b0;
            n_cmp++; if ({b1.out_valid, b16.out_valid, b1.in_ready, b16.in_ready} !== 4'b0011) begin n_err++; $display("FAIL lanes_release_%0d: got %b want 0011", v, {b1.out_valid, b16.out_valid, b1.in_ready, b16.in_ready}); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        b4.in_valid = 1'b0;  b4.in_data = '0;  b4.out_ready = 1'b0;
        b1.in_valid = 1'b0;  b1.in_data = '0;  b1.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_mapping();
        test_table();
        test_backpressure();
        test_reset_mid_run();
        test_lanes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
